// File: rtl/spi_mst_arb.sv
// Round-robin arbiter that lets NREQ requesters share one SPI master.
// Each transaction is launched, waits for master busy (with timeout), and returns the read payload.
module spi_mst_arb #(
  parameter int NREQ     = 4,
  parameter int BUSY_TMO = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [4*NREQ-1:0]    req_len,
  input  logic [128*NREQ-1:0]  req_data,
  output logic [NREQ-1:0]      req_rdy,
  output logic [NREQ-1:0]      rsp_vld,
  output logic [127:0]         rsp_data,
  output logic                 rsp_err,
  output logic [127:0]         mst_wfifo,
  output logic [7:0]           mst_ctrl,
  input  logic [127:0]         mst_rfifo,
  input  logic [7:0]           mst_status
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t          state_r;
  logic [GW-1:0]   last_grant_r;
  logic [GW-1:0]   grant_r;
  logic [7:0]      tmo_cnt_r;
  logic [GW-1:0]   gnt_idx_s;
  logic            gnt_any_s;
  logic            busy_s;
  logic            unused_status_s;

  assign busy_s          = mst_status[7];
  assign unused_status_s = ^mst_status[6:0];

  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] idx);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin pick: descending scan so the nearest requester after last_grant overwrites the rest.
  always_comb begin
    logic [GW-1:0] cand_v;
    gnt_idx_s = '0;
    cand_v    = '0;
    gnt_any_s = |req_vld;
    for (int k = NREQ; k >= 1; k--) begin
      cand_v    = GW'((int'(last_grant_r) + k) % NREQ);
      gnt_idx_s = req_vld[cand_v] ? cand_v : gnt_idx_s;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      last_grant_r <= GW'(NREQ - 1);
      grant_r      <= '0;
      tmo_cnt_r    <= 8'd0;
      req_rdy      <= '0;
      rsp_vld      <= '0;
      rsp_err      <= 1'b0;
      rsp_data     <= 128'h0;
      mst_wfifo    <= 128'h0;
      mst_ctrl     <= 8'h00;
    end else begin
      req_rdy  <= '0;
      rsp_vld  <= '0;
      rsp_err  <= 1'b0;
      mst_ctrl <= 8'h00;
      case (state_r)
        IDLE: begin
          if (gnt_any_s) begin
            grant_r      <= gnt_idx_s;
            last_grant_r <= gnt_idx_s;
            req_rdy      <= onehot(gnt_idx_s);
            mst_wfifo    <= req_data[gnt_idx_s*128 +: 128];
            mst_ctrl     <= {1'b1, 3'b000, req_len[gnt_idx_s*4 +: 4]};
            tmo_cnt_r    <= 8'd0;
            state_r      <= LAUNCH;
          end else begin
            state_r <= IDLE;
          end
        end
        LAUNCH: begin
          state_r <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (busy_s) begin
            state_r <= WAIT_DONE;
          end else if (tmo_cnt_r == 8'(BUSY_TMO)) begin
            // Timeout fires once BUSY_TMO idle cycles have been counted.
            rsp_vld  <= onehot(grant_r);
            rsp_err  <= 1'b1;
            rsp_data <= 128'h0;
            state_r  <= RESP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!busy_s) begin
            rsp_vld  <= onehot(grant_r);
            rsp_data <= mst_rfifo;
            state_r  <= RESP;
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mst_arb.sv
// Directed bench for spi_mst_arb with a small SPI master model that inverts the top write byte.
module tb_spi_mst_arb;
  localparam int NREQ = 4;
  localparam int BUSY_TMO = 8;

  logic clk = 1'b0;
  logic rstn;
  logic [NREQ-1:0]     req_vld;
  logic [4*NREQ-1:0]   req_len;
  logic [128*NREQ-1:0] req_data;
  logic [NREQ-1:0]     req_rdy;
  logic [NREQ-1:0]     rsp_vld;
  logic [127:0]        rsp_data;
  logic                rsp_err;
  logic [127:0]        mst_wfifo;
  logic [7:0]          mst_ctrl;
  logic [127:0]        mst_rfifo;
  logic [7:0]          mst_status;

  int vectors = 0;
  int miscompares = 0;
  logic master_en;
  int m_cnt;

  spi_mst_arb #(.NREQ(NREQ), .BUSY_TMO(BUSY_TMO)) dut (
    .clk(clk), .rstn(rstn), .req_vld(req_vld), .req_len(req_len), .req_data(req_data),
    .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mst_wfifo(mst_wfifo), .mst_ctrl(mst_ctrl), .mst_rfifo(mst_rfifo), .mst_status(mst_status)
  );

  always #5 clk = ~clk;

  // Master model: sees start, goes busy one cycle later for three cycles, returns ~top byte.
  initial begin
    m_cnt = 0;
    mst_status = 8'h00;
    mst_rfifo = 128'h0;
    forever begin
      @(negedge clk);
      if (!rstn) m_cnt = 0;
      else if (master_en && mst_ctrl[7]) begin
        m_cnt = 4;
        mst_rfifo = {120'h0, ~mst_wfifo[127:120]};
      end else if (m_cnt > 0) m_cnt = m_cnt - 1;
      mst_status = (m_cnt >= 1 && m_cnt <= 3) ? 8'h80 : 8'h00;
    end
  end

  task automatic wait_rdy(output logic [NREQ-1:0] seen);
    seen = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_rdy != '0) begin
        seen = req_rdy;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output logic [NREQ-1:0] seen, output logic err, output logic [127:0] data,
                          output int cyc);
    seen = '0; err = 1'b0; data = 128'h0; cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (rsp_vld != '0) begin
        seen = rsp_vld; err = rsp_err; data = rsp_data;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    @(negedge clk);
    vectors++; if (req_rdy !== 4'b0000) begin miscompares++; $display("FAIL reset_req_rdy got %b exp 0000", req_rdy); end
    vectors++; if (rsp_vld !== 4'b0000) begin miscompares++; $display("FAIL reset_rsp_vld got %b exp 0000", rsp_vld); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    vectors++; if (rsp_data !== 128'h0) begin miscompares++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    vectors++; if (mst_wfifo !== 128'h0) begin miscompares++; $display("FAIL reset_wfifo got %h exp 0", mst_wfifo); end
    vectors++; if (mst_ctrl !== 8'h00) begin miscompares++; $display("FAIL reset_ctrl got %h exp 00", mst_ctrl); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [NREQ-1:0] seen; logic err; logic [127:0] data; int cyc;
    logic [127:0] d;
    d = 128'h5a << 120;
    req_len[3:0] = 4'h0;
    req_data[127:0] = d;
    req_vld = 4'b0001;
    wait_rdy(seen);
    req_vld = 4'b0000;
    vectors++; if (seen !== 4'b0001) begin miscompares++; $display("FAIL single_rdy got %b exp 0001", seen); end
    vectors++; if (mst_ctrl !== 8'h80) begin miscompares++; $display("FAIL single_ctrl got %h exp 80", mst_ctrl); end
    vectors++; if (mst_wfifo !== d) begin miscompares++; $display("FAIL single_wfifo got %h exp %h", mst_wfifo, d); end
    @(negedge clk);
    vectors++; if (req_rdy !== 4'b0000 || mst_ctrl !== 8'h00) begin
      miscompares++; $display("FAIL single_pulse got rdy %b ctrl %h exp 0000/00", req_rdy, mst_ctrl); end
    wait_rsp(seen, err, data, cyc);
    vectors++; if (seen !== 4'b0001) begin miscompares++; $display("FAIL single_rsp_vld got %b exp 0001", seen); end
    vectors++; if (data !== {120'h0, 8'ha5}) begin miscompares++; $display("FAIL single_rsp_data got %h exp a5", data); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL single_rsp_err got %b exp 0", err); end
    @(negedge clk);
    vectors++; if (rsp_vld !== 4'b0000) begin miscompares++; $display("FAIL single_rsp_pulse got %b exp 0000", rsp_vld); end
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] seen; logic [NREQ-1:0] rseen; logic err; logic [127:0] data; int cyc;
    logic [NREQ-1:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    req_vld = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_rdy(seen);
      if (t == 4) req_vld = 4'b0000;
      vectors++; if (seen !== exp_g[t]) begin miscompares++; $display("FAIL rr_grant%0d got %b exp %b", t, seen, exp_g[t]); end
      @(negedge clk);
      vectors++; if (req_rdy !== 4'b0000) begin miscompares++; $display("FAIL rr_single_rdy%0d got %b exp 0000", t, req_rdy); end
      wait_rsp(rseen, err, data, cyc);
      vectors++; if (rseen !== exp_g[t]) begin miscompares++; $display("FAIL rr_rsp%0d got %b exp %b", t, rseen, exp_g[t]); end
    end
  endtask

  task automatic test_fairness;
    logic [NREQ-1:0] seen; logic [NREQ-1:0] rseen; logic err; logic [127:0] data; int cyc;
    logic [NREQ-1:0] pat [3];
    logic [NREQ-1:0] exp_g [3];
    pat   = '{4'b0100, 4'b0101, 4'b0100};
    exp_g = '{4'b0100, 4'b0001, 4'b0100};
    for (int t = 0; t < 3; t++) begin
      req_vld = pat[t];
      wait_rdy(seen);
      req_vld = 4'b0000;
      vectors++; if (seen !== exp_g[t]) begin miscompares++; $display("FAIL fair_grant%0d got %b exp %b", t, seen, exp_g[t]); end
      wait_rsp(rseen, err, data, cyc);
    end
  endtask

  task automatic test_timeout;
    logic [NREQ-1:0] seen; logic err; logic [127:0] data; int cyc;
    master_en = 1'b0;
    req_vld = 4'b0010;
    wait_rdy(seen);
    req_vld = 4'b0000;
    vectors++; if (seen !== 4'b0010) begin miscompares++; $display("FAIL tmo_grant got %b exp 0010", seen); end
    wait_rsp(seen, err, data, cyc);
    vectors++; if (cyc !== 10) begin miscompares++; $display("FAIL tmo_latency got %0d exp 10", cyc); end
    vectors++; if (seen !== 4'b0010) begin miscompares++; $display("FAIL tmo_rsp_vld got %b exp 0010", seen); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL tmo_rsp_err got %b exp 1", err); end
    vectors++; if (data !== 128'h0) begin miscompares++; $display("FAIL tmo_rsp_data got %h exp 0", data); end
    master_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stability;
    logic [NREQ-1:0] seen; logic err; logic [127:0] data; int cyc;
    logic [127:0] d1;
    d1 = 128'hdead_beef_0123_4567_89ab_cdef_0011_2233;
    req_len[3:0] = 4'h3;
    req_data[127:0] = d1;
    req_vld = 4'b0001;
    wait_rdy(seen);
    req_vld = 4'b0000;
    vectors++; if (seen !== 4'b0001) begin miscompares++; $display("FAIL stab_grant got %b exp 0001", seen); end
    vectors++; if (mst_ctrl !== 8'h83) begin miscompares++; $display("FAIL stab_ctrl got %h exp 83", mst_ctrl); end
    @(negedge clk);
    @(negedge clk);
    req_data[127:0] = ~d1;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (mst_wfifo !== d1) begin miscompares++; $display("FAIL stab_wfifo%0d got %h exp %h", i, mst_wfifo, d1); end
      vectors++; if (mst_ctrl[7] !== 1'b0) begin miscompares++; $display("FAIL stab_start%0d got %b exp 0", i, mst_ctrl[7]); end
      @(negedge clk);
    end
    wait_rsp(seen, err, data, cyc);
    vectors++; if (seen !== 4'b0001 || err !== 1'b0) begin
      miscompares++; $display("FAIL stab_rsp got vld %b err %b exp 0001/0", seen, err); end
    vectors++; if (data !== {120'h0, 8'h21}) begin miscompares++; $display("FAIL stab_rsp_data got %h exp 21", data); end
  endtask

  task automatic test_reset_mid;
    logic [NREQ-1:0] seen; logic err; logic [127:0] data; int cyc;
    int pulses;
    req_vld = 4'b0100;
    wait_rdy(seen);
    req_vld = 4'b0000;
    vectors++; if (seen !== 4'b0100) begin miscompares++; $display("FAIL rmid_grant got %b exp 0100", seen); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    vectors++; if (req_rdy !== 4'b0000 || rsp_vld !== 4'b0000 || rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL rmid_ctl got rdy %b vld %b err %b exp 0", req_rdy, rsp_vld, rsp_err); end
    vectors++; if (mst_wfifo !== 128'h0) begin miscompares++; $display("FAIL rmid_wfifo got %h exp 0", mst_wfifo); end
    vectors++; if (rsp_data !== 128'h0) begin miscompares++; $display("FAIL rmid_rsp_data got %h exp 0", rsp_data); end
    vectors++; if (mst_ctrl !== 8'h00) begin miscompares++; $display("FAIL rmid_ctrl got %h exp 00", mst_ctrl); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_vld != 4'b0000) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL rmid_no_rsp got %0d pulses exp 0", pulses); end
    req_vld = 4'b1111;
    wait_rdy(seen);
    req_vld = 4'b0000;
    vectors++; if (seen !== 4'b0001) begin miscompares++; $display("FAIL rmid_next_grant got %b exp 0001", seen); end
    wait_rsp(seen, err, data, cyc);
  endtask

  initial begin
    rstn = 1'b0;
    master_en = 1'b1;
    req_vld = '0;
    req_len = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_timeout();
    test_stability();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
